leaf_switch: RTL
================

Name: leaf_switch

Overview:
- Leaf-level router stage directly downstream of four GPU network interfaces; consumes their routed flits and returns flits addressed to them.
- Each 16-bit flit is a self-contained single-word packet: [15:10] routing header (4-bit group, 2-bit leaf), [9:0] payload.
- Routes flits among 4 local ports (leaf 0..3) and one uplink toward the group-level fabric.
- Per-input buffering; per-output round-robin arbitration.

Parameters:
- DATA_W, 16, flit width.
- HEADER_W, 6, routing header width at flit MSBs.
- GROUP_ID, 2, 4-bit group served by this leaf (GPUs 5..8 for default).
- FIFO_DEPTH, 4, entries per input FIFO; power of two, >=2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- loc_in_data  in  4*DATA_W  flits from NI i in bits [i*DATA_W +: DATA_W].
- loc_in_valid  in  4  per-port flit valid from NIs.
- loc_in_ready  out  4  per-port ready to NIs.
- loc_out_data  out  4*DATA_W  flits to NIs.
- loc_out_valid  out  4  one-cycle flit pulse to NIs; no backpressure.
- up_in_data  in  DATA_W  flit from group fabric.
- up_in_valid  in  1  uplink ingress valid.
- up_in_ready  out  1  uplink ingress ready.
- up_out_data  out  DATA_W  flit to group fabric.
- up_out_valid  out  1  uplink egress valid.
- up_out_ready  in  1  uplink egress ready.

Behaviour:
- Reset: clk, clock; reset, asynchronous active-high. All outputs 0, FIFOs empty, RR pointers 0. All in_ready are 0 while reset is asserted.
- Input index: 0..3 local, 4 uplink.
- Ingress: flit is written when valid=1 and FIFO not full, regardless of ready.
- in_ready=1 iff count <= FIFO_DEPTH-2. The spare slot absorbs the NI's one-cycle-late valid.
- A flit arriving while the FIFO is full is discarded. This is not reachable with compliant senders.
- Route decode on the FIFO head:
  - Header 0: invalid, pop and drop.
  - header[5:2]==GROUP_ID: local port header[1:0]. Loopback to the source port is allowed.
  - Otherwise: uplink.
  - Uplink-sourced flit decoded to uplink (U-turn): pop and drop.
  - Drops take one cycle and need no grant.
- Arbitration: per output, round-robin over requesting inputs, starting at ptr.
  - After a grant to input g, ptr becomes (g+1) mod 5. Ptr holds when there is no grant.
  - At most one pop per input per cycle. An input requests only one output, so there are no conflicts.
- Local egress: loc_out_valid[p] <= grant; loc_out_data[p] <= granted head, held when there is no grant.
- Uplink egress: standard valid/ready through an output register.
  - The register loads when empty or when up_out_ready=1 in the same cycle (full throughput).
  - up_out_data is held stable while up_out_valid=1 and up_out_ready=0.
- Latency: a flit accepted at edge E appears on the output in the cycle after edge E+1, assuming no contention.
- Simultaneous write and pop on the same FIFO: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all buffered and in-flight flits are discarded immediately. Outputs go to 0 asynchronously.

Optional Feature:
- LEAF_SW_STATS_EN defined:
  - Adds output port drop_cnt [7:0].
  - Saturating count of dropped flits: header 0, U-turn, or overflow.
  - Reset to 0. Saturates at 8'hFF.
  - If two drops occur in one cycle, the counter adds 2, saturating.
- Undefined: no port, no counter. Drops are silent.

Decomposition:
- Package leaf_sw_pkg:
  - DATA_W, HEADER_W.
  - Group and leaf field bit positions.
  - Port-index constants LOC0..LOC3 and UP=4; NUM_IN=5.
  - Route-decode function (header, GROUP_ID -> dest index or DROP).
- Sub-module leaf_sw_fifo: synchronous FIFO with count, full, empty and skid-ready output; 5 instances.
- Arbiters stay inline.

Test Plan:
- Local route: loc0 sends 16'h2D55 (hdr 001011) -> loc_out_valid[3] pulses once with 16'h2D55 in the cycle after edge E+1. No other valid.
- Uplink route: loc1 sends 16'h4001 (group 4) with up_out_ready=1 -> up_out_data=16'h4001 for one cycle.
- Contention: loc0..3 each send one flit to leaf 3 in the same cycle -> loc_out_valid[3] high 4 consecutive cycles, sources in order 0,1,2,3. Then the next simultaneous burst also starts at input 4, then 0.
- Backpressure: up_out_ready=0, loc2 streams 6 uplink flits with FIFO_DEPTH=4:
  - up_out_data is held.
  - loc_in_ready[2] drops once count reaches 3.
  - No flit is lost.
  - Releasing ready drains flits in order.
- Drops: loc0 sends 16'h0012; uplink sends 16'h4000 -> no output. With LEAF_SW_STATS_EN, drop_cnt=2.
- Reset mid-operation: reset asserted with 3 flits buffered -> all valids 0 immediately. After release, no stale flit appears and in_ready=1.

Source files
------------

// File: rtl/leaf_sw_pkg.sv
// Shared constants and route decode for the leaf-level router stage.
// Flit layout: [15:12] group, [11:10] leaf, [9:0] payload.
package leaf_sw_pkg;
  localparam int DATA_W   = 16;
  localparam int HEADER_W = 6;
  localparam int GRP_MSB  = DATA_W - 1;
  localparam int GRP_LSB  = DATA_W - 4;
  localparam int LEAF_MSB = DATA_W - 5;
  localparam int LEAF_LSB = DATA_W - HEADER_W;
  localparam int NUM_IN   = 5;

  localparam logic [2:0] LOC0 = 3'd0;
  localparam logic [2:0] LOC1 = 3'd1;
  localparam logic [2:0] LOC2 = 3'd2;
  localparam logic [2:0] LOC3 = 3'd3;
  localparam logic [2:0] UP   = 3'd4;
  localparam logic [2:0] DROP = 3'd7;

  // Header 0 is invalid; own group goes to a leaf port, anything else leaves via uplink.
  function automatic logic [2:0] route(input logic [HEADER_W-1:0] hdr, input logic [3:0] grp);
    if (hdr == '0)
      return DROP;
    else if (hdr[HEADER_W-1 -: 4] == grp)
      return {1'b0, hdr[1:0]};
    else
      return UP;
  endfunction
endpackage

// File: rtl/leaf_sw_fifo.sv
// Per-input synchronous FIFO; ready is held back one slot early so a
// sender reacting a cycle late never overruns it.
module leaf_sw_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ready
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign ready = !reset && (count <= (AW+1)'(DEPTH - 2));
  assign wr    = wr_valid && !full;
  assign rd    = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (!wr && rd) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/leaf_switch.sv
// Leaf router: 4 local ports + uplink, per-input FIFOs, per-output round-robin.
// Build with LEAF_SW_STATS_EN to add the saturating drop_cnt output.
module leaf_switch
  import leaf_sw_pkg::*;
#(
  parameter logic [3:0] GROUP_ID   = 4'd2,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DATA_W-1:0]   loc_in_data,
  input  logic [3:0]            loc_in_valid,
  output logic [3:0]            loc_in_ready,
  output logic [4*DATA_W-1:0]   loc_out_data,
  output logic [3:0]            loc_out_valid,
  input  logic [DATA_W-1:0]     up_in_data,
  input  logic                  up_in_valid,
  output logic                  up_in_ready,
  output logic [DATA_W-1:0]     up_out_data,
  output logic                  up_out_valid,
  input  logic                  up_out_ready
`ifdef LEAF_SW_STATS_EN
  , output logic [7:0]          drop_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_IN-1:0][DATA_W-1:0] in_data, head;
  logic [NUM_IN-1:0][CW-1:0]     count;
  logic [NUM_IN-1:0]             in_valid, in_rdy, empty, full, pop, drop;
  logic [NUM_IN-1:0][2:0]        dest, ptr;
  logic [NUM_IN-1:0][NUM_IN-1:0] req;
  logic [NUM_IN-1:0][3:0]        pick;
  logic                          up_can;
  logic                          unused_count;

  assign in_valid     = {up_in_valid, loc_in_valid};
  assign loc_in_ready = in_rdy[3:0];
  assign up_in_ready  = in_rdy[4];
  assign up_can       = !up_out_valid || up_out_ready;
  assign unused_count = ^count;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    if (i < 4) begin : g_loc
      assign in_data[i] = loc_in_data[i*DATA_W +: DATA_W];
    end else begin : g_up
      assign in_data[i] = up_in_data;
    end
    leaf_sw_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset),
      .wr_valid(in_valid[i]), .wr_data(in_data[i]), .pop(pop[i]),
      .head(head[i]), .count(count[i]), .full(full[i]), .empty(empty[i]), .ready(in_rdy[i])
    );
  end

  // Returns {found, index}: first requester at or after ptr, wrapping mod NUM_IN.
  function automatic logic [3:0] rr_pick(input logic [NUM_IN-1:0] r, input logic [2:0] p);
    logic [3:0] sum;
    logic [2:0] idx;
    logic [3:0] res;
    res = '0;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      sum = {1'b0, p} + 4'(k);
      idx = (sum >= 4'(NUM_IN)) ? 3'(sum - 4'(NUM_IN)) : sum[2:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    req  = '0;
    drop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      dest[i] = route(head[i][DATA_W-1 -: HEADER_W], GROUP_ID);
      if (i == int'(UP) && dest[i] == UP) dest[i] = DROP;
      drop[i] = !empty[i] && (dest[i] == DROP);
      for (int o = 0; o < NUM_IN; o++)
        req[o][i] = !empty[i] && (dest[i] == 3'(o));
    end
    if (!up_can) req[UP] = '0;
    pop = drop;
    for (int o = 0; o < NUM_IN; o++) begin
      pick[o] = rr_pick(req[o], ptr[o]);
      if (pick[o][3]) pop[pick[o][2:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr           <= '0;
      loc_out_valid <= '0;
      loc_out_data  <= '0;
      up_out_valid  <= 1'b0;
      up_out_data   <= '0;
    end else begin
      for (int o = 0; o < NUM_IN; o++)
        if (pick[o][3]) ptr[o] <= (pick[o][2:0] == UP) ? 3'd0 : pick[o][2:0] + 3'd1;
      for (int p = 0; p < 4; p++) begin
        loc_out_valid[p] <= pick[p][3];
        if (pick[p][3]) loc_out_data[p*DATA_W +: DATA_W] <= head[pick[p][2:0]];
      end
      // Uplink grants only happen when the output register can take a new flit.
      if (pick[UP][3]) begin
        up_out_valid <= 1'b1;
        up_out_data  <= head[pick[UP][2:0]];
      end else if (up_out_ready) begin
        up_out_valid <= 1'b0;
      end
    end
  end

`ifdef LEAF_SW_STATS_EN
  logic [NUM_IN-1:0] ovf;
  logic [3:0]        n_drop;
  logic [8:0]        cnt_sum;

  assign ovf = in_valid & full;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_IN; i++)
      n_drop = n_drop + 4'(drop[i]) + 4'(ovf[i]);
    cnt_sum = {1'b0, drop_cnt} + 9'(n_drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              drop_cnt <= '0;
    else if (cnt_sum[8])    drop_cnt <= 8'hFF;
    else                    drop_cnt <= cnt_sum[7:0];
  end
`endif
endmodule
